// File: rtl/if_id_buffer_pkg.sv
// Shared constants for the fetch/decode decoupling buffer.
package if_id_buffer_pkg;

    localparam logic [31:0] NOP_INST      = 32'h0000_0000;
    localparam logic [31:0] PC_INCR       = 32'd4;
    localparam int          IF_ID_ENTRY_W = 64;

endpackage : if_id_buffer_pkg

// File: rtl/cla_32.sv
// 32-bit carry-lookahead adder: eight 4-bit lookahead groups chained on group carry.
module CLA_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in,
    output logic [31:0] sum,
    output logic        c_out
);

    // One 4-bit lookahead group; returns {carry_out, sum[3:0]}.
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c[4], p ^ c[3:0]};
    endfunction

    logic [8:0] grp_c_s;
    logic [4:0] grp_r_s [8];

    assign grp_c_s[0] = c_in;

    for (genvar gi = 0; gi < 8; gi++) begin : g_grp
        assign grp_r_s[gi]       = cla4(a[4*gi +: 4], b[4*gi +: 4], grp_c_s[gi]);
        assign sum[4*gi +: 4]    = grp_r_s[gi][3:0];
        assign grp_c_s[gi + 1]   = grp_r_s[gi][4];
    end

    assign c_out = grp_c_s[8];

endmodule : CLA_32

// File: rtl/if_id_entry.sv
// One {pc, instruction} slot of the fetch/decode buffer.
module if_id_entry
    import if_id_buffer_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [IF_ID_ENTRY_W-1:0] d,
    output logic [IF_ID_ENTRY_W-1:0] q
);

    register_n #(.N(IF_ID_ENTRY_W)) u_reg (
        .clk   (clk),
        .reset (reset),
        .wr_en (wr_en),
        .d     (d),
        .q     (q)
    );

endmodule : if_id_entry

// File: rtl/mux_n.sv
// Generic N-bit 2:1 multiplexer; sel = 0 selects a.
module mux_n #(
    parameter int N = 32
) (
    input  logic         sel,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y
);

    // Pure select, no storage.
    always_comb begin
        if (sel) begin
            y = b;
        end else begin
            y = a;
        end
    end

endmodule : mux_n

// File: rtl/register_n.sv
// Generic N-bit register with synchronous active-high clear and write enable.
module register_n #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] data_q;

    // Clear on reset, load on write enable, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= {N{1'b0}};
        end else if (wr_en) begin
            data_q <= d;
        end else begin
            data_q <= data_q;
        end
    end

    assign q = data_q;

endmodule : register_n

// File: rtl/if_id_buffer.sv
// Fetch-to-decode decoupling FIFO of {pc, instruction} pairs with valid/ready
// on both sides. Flush (taken redirect) and reset empty it; outputs show a
// NOP bubble at pc 0 whenever the buffer is empty.
module if_id_buffer
    import if_id_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [31:0]  in_pc,
    input  logic [31:0]  in_inst,
    output logic         in_ready,
    output logic         out_valid,
    output logic [31:0]  out_pc,
    output logic [31:0]  out_pc4,
    output logic [31:0]  out_inst,
    input  logic         out_ready,
    output logic [PTR_W:0] count
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;

    logic                     push_s;
    logic                     pop_s;
    logic [DEPTH-1:0]         wr_en_s;
    logic [IF_ID_ENTRY_W-1:0] wr_data_s;
    logic [IF_ID_ENTRY_W-1:0] entry_s [DEPTH];
    logic [IF_ID_ENTRY_W-1:0] head_s;
    logic                     pc4_cout_unused_s;

    // Ready/valid come straight from registered occupancy: no out_ready -> in_ready path.
    assign in_ready  = (count_q != FULL_COUNT);
    assign out_valid = (count_q != {(PTR_W + 1){1'b0}});
    assign push_s    = in_valid & in_ready;
    assign pop_s     = out_valid & out_ready;
    assign wr_data_s = {in_pc, in_inst};
    assign count     = count_q;

    // Storage slots; a flush-cycle word is the wrong-path word and is never written.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        assign wr_en_s[i] = push_s & ~flush & (wr_ptr_q == PTR_W'(i));
        if_id_entry u_entry (
            .clk   (clk),
            .reset (reset),
            .wr_en (wr_en_s[i]),
            .d     (wr_data_s),
            .q     (entry_s[i])
        );
    end

    // Read-side DEPTH:1 mux tree; level l picks between sibling pairs using rd_ptr bit l.
    for (genvar l = 0; l < PTR_W; l++) begin : g_lvl
        localparam int NODES = DEPTH >> (l + 1);
        logic [IF_ID_ENTRY_W-1:0] y_s [NODES];
        for (genvar j = 0; j < NODES; j++) begin : g_node
            if (l == 0) begin : g_leaf
                mux_n #(.N(IF_ID_ENTRY_W)) u_mux (
                    .sel (rd_ptr_q[l]),
                    .a   (entry_s[2*j]),
                    .b   (entry_s[2*j + 1]),
                    .y   (y_s[j])
                );
            end else begin : g_inner
                mux_n #(.N(IF_ID_ENTRY_W)) u_mux (
                    .sel (rd_ptr_q[l]),
                    .a   (g_lvl[l-1].y_s[2*j]),
                    .b   (g_lvl[l-1].y_s[2*j + 1]),
                    .y   (y_s[j])
                );
            end
        end
    end

    assign head_s = g_lvl[PTR_W-1].y_s[0];

    // Empty buffer presents a NOP bubble at pc 0, regardless of stale slot contents.
    always_comb begin
        out_pc   = 32'h0000_0000;
        out_inst = NOP_INST;
        if (out_valid) begin
            out_pc   = head_s[63:32];
            out_inst = head_s[31:0];
        end else begin
            out_pc   = 32'h0000_0000;
            out_inst = NOP_INST;
        end
    end

    // Branch-target helper: head pc + 4, carry-out dropped (wraps modulo 2^32).
    CLA_32 u_pc4_add (
        .a     (out_pc),
        .b     (PC_INCR),
        .c_in  (1'b0),
        .sum   (out_pc4),
        .c_out (pc4_cout_unused_s)
    );

    // Next pointer/occupancy: flush drops everything, else apply push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {(PTR_W + 1){1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    count_d  = count_q + (PTR_W + 1)'(1);
                end
                2'b01: begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    count_d  = count_q - (PTR_W + 1)'(1);
                end
                2'b11: begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end
                default: begin
                    wr_ptr_d = wr_ptr_q;
                    rd_ptr_d = rd_ptr_q;
                    count_d  = count_q;
                end
            endcase
        end
    end

    // Pointer/occupancy state; reset has priority over flush and handshakes.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {(PTR_W + 1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule : if_id_buffer

// File: tb/tb_if_id_buffer.sv
// Directed self-checking bench for if_id_buffer.
module tb_if_id_buffer;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic [31:0] out_inst;
    logic        out_ready;
    logic [2:0]  count;

    int tests_run    = 0;
    int tests_failed = 0;

    if_id_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_pc4   (out_pc4),
        .out_inst  (out_inst),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_count"},     {29'd0, count},     32'd0);
        chk({tag, "_out_inst"},  out_inst,           32'h0000_0000);
        chk({tag, "_out_pc"},    out_pc,             32'h0000_0000);
        chk({tag, "_out_pc4"},   out_pc4,            32'h0000_0004);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_pc = 32'h0; in_inst = 32'h0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk_reset_state("post_reset");

        // Fill to full with decode stalled.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'(i * 4);
            in_inst  = 32'hA0 + 32'(i);
            tick();
            chk("fill_count", {29'd0, count}, 32'(i + 1));
        end
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);

        // Fifth word must be refused while full.
        in_pc = 32'h10; in_inst = 32'hA4;
        tick();
        chk("full_count",    {29'd0, count}, 32'd4);
        chk("full_out_pc",   out_pc,         32'h00);
        chk("full_out_pc4",  out_pc4,        32'h04);
        chk("full_out_inst", out_inst,       32'hA0);

        // Stream: pop every cycle, fetch offers the next word every cycle.
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_pc   = (k == 0) ? 32'h10 : 32'h10 + 32'(4 * (k - 1));
            in_inst = 32'hA0 + (in_pc >> 2);
            chk("stream_valid", {31'd0, out_valid}, 32'd1);
            chk("stream_pc",    out_pc,   32'(4 * k));
            chk("stream_inst",  out_inst, 32'hA0 + 32'(k));
            tick();
            chk("stream_count", {29'd0, count}, 32'd3);
        end

        // Drain the remaining three (0x18, 0x1C, 0x20).
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("drain_pc",   out_pc,   32'h18 + 32'(4 * k));
            chk("drain_inst", out_inst, 32'hA6 + 32'(k));
            tick();
        end
        chk("empty_count",    {29'd0, count},     32'd0);
        chk("empty_valid",    {31'd0, out_valid}, 32'd0);
        chk("empty_out_pc",   out_pc,             32'h0);
        chk("empty_out_inst", out_inst,           32'h0);
        chk("empty_out_pc4",  out_pc4,            32'h4);

        // Pop request on empty is ignored.
        tick();
        chk("underflow_count", {29'd0, count},    32'd0);
        chk("underflow_ready", {31'd0, in_ready}, 32'd1);

        // Push, then push+pop in the same cycle.
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h20; in_inst = 32'hB0;
        tick();
        chk("single_count", {29'd0, count}, 32'd1);
        chk("single_pc",    out_pc,         32'h20);
        in_pc = 32'h24; in_inst = 32'hB1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("pushpop_count", {29'd0, count}, 32'd1);
        chk("pushpop_pc",    out_pc,         32'h24);
        chk("pushpop_inst",  out_inst,       32'hB1);
        chk("pushpop_pc4",   out_pc4,        32'h28);

        // Flush with three held and a wrong-path word offered.
        in_valid = 1'b1; in_pc = 32'h28; in_inst = 32'hB2; tick();
        in_pc = 32'h2C; in_inst = 32'hB3; tick();
        chk("preflush_count", {29'd0, count}, 32'd3);
        flush = 1'b1; in_pc = 32'h30; in_inst = 32'hB4;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_count", {29'd0, count},     32'd0);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b1; in_pc = 32'h40; in_inst = 32'hC0;
        tick();
        in_valid = 1'b0;
        chk("postflush_count", {29'd0, count}, 32'd1);
        chk("postflush_pc",    out_pc,         32'h40);
        chk("postflush_inst",  out_inst,       32'hC0);

        // Flush from full releases in_ready on the next cycle.
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_pc = 32'h44 + 32'(4 * i); in_inst = 32'hC1 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        chk("full2_count", {29'd0, count},    32'd4);
        chk("full2_ready", {31'd0, in_ready}, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flushfull_ready", {31'd0, in_ready}, 32'd1);
        chk("flushfull_count", {29'd0, count},    32'd0);

        // pc+4 wraps at the top of the address space.
        in_valid = 1'b1; in_pc = 32'hFFFF_FFFC; in_inst = 32'hD0;
        tick();
        in_valid = 1'b0;
        chk("wrap_valid", {31'd0, out_valid}, 32'd1);
        chk("wrap_pc",    out_pc,             32'hFFFF_FFFC);
        chk("wrap_pc4",   out_pc4,            32'h0000_0000);

        // Reset mid-stream with a push offered: everything returns to reset values.
        reset = 1'b1; in_valid = 1'b1; in_pc = 32'h50; in_inst = 32'hE0;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        chk_reset_state("midreset");
        tick();
        chk("midreset_idle_count", {29'd0, count}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_if_id_buffer
